// File: rtl/dcache_mem_pkg.sv
// Shared types for the dcache <-> backing-memory line interface.
// Imported by the memory model and the dcache controller.
package dcache_mem_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    typedef logic [LINE_BITS-1:0] line_t;

endpackage

// File: rtl/dcache_backing_memory_mem_line_array.sv
// Line storage for the dcache backing memory: single port, registered read.
// Kept apart so an SRAM macro can replace it without touching the FSM.
module mem_line_array #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 512,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dcache_backing_memory.sv
// Fixed-latency line memory answering dcache refills and write-backs.
// One request at a time; a one-cycle ack ends each transfer.
module dcache_backing_memory #(
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 10,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 busy_o
);

    import dcache_mem_pkg::*;

    localparam int         IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LAST  = 8'(LATENCY - 1);

    state_t               state;
    state_t               state_n;
    logic [7:0]           cnt;
    logic [7:0]           cnt_n;
    logic                 accept;
    logic                 we;
    logic                 rd_done;
    logic                 wr_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     addr_idx;
    logic [IDX_W-1:0]     arr_idx;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata;
    logic                 unused_addr;

    assign addr_idx = addr_i[OFFSET_BITS +: IDX_W];
    assign unused_addr = ^{addr_i[OFFSET_BITS-1:0],
                           addr_i[ADDR_W-1:OFFSET_BITS+IDX_W]};

    // Address the array straight from the bus while idle so the
    // registered read is already valid on the edge after accept.
    assign arr_idx = (state == IDLE) ? addr_idx : idx_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        we      = 1'b0;
        rd_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i) begin
                    state_n = BUSY;
                    cnt_n   = 8'd1;
                    accept  = 1'b1;
                end
            end
            BUSY: begin
                cnt_n = cnt + 8'd1;
                if (cnt == LAST) begin
                    state_n = ACK;
                    we      = wr_q;
                    rd_done = ~wr_q;
                end
            end
            ACK: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            data_o <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (rd_done) begin
                data_o <= rdata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_q    <= write_i;
            idx_q   <= addr_idx;
            wdata_q <= data_i;
        end
    end

    assign ack_o  = (state == ACK);
    assign busy_o = (state != IDLE);

    mem_line_array #(
        .LINE_BITS (LINE_BITS),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .we    (we & ~rst_i),
        .idx   (arr_idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dcache_backing_memory.sv
// Bench for dcache_backing_memory: vector table, corner sequences and
// random traffic against an array model of the line store.
module tb_dcache_backing_memory;

    import dcache_mem_pkg::*;

    localparam int LAT   = 10;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        wr_s;
    logic [31:0] addr;
    line_t       din;
    logic        ack;
    line_t       dout;
    logic        busy;

    int    nchk = 0;
    int    nerr = 0;
    line_t model [DEPTH];
    line_t hold;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        line_t       data;
        line_t       exp;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    dcache_backing_memory #(
        .LINE_BITS (256),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .ADDR_W    (32)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr_s),
        .addr_i   (addr),
        .data_i   (din),
        .ack_o    (ack),
        .data_o   (dout),
        .busy_o   (busy)
    );

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(output int edges, output int busy_n,
                            output bit ok);
        edges  = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (busy) busy_n++;
            if (ack) ok = 1'b1;
        end
    endtask

    task automatic xact(input bit w, input logic [31:0] a, input line_t d,
                        input string nm, output line_t q);
        int e;
        int b;
        bit ok;
        @(negedge clk);
        en   = 1'b1;
        wr_s = w;
        addr = a;
        din  = d;
        wait_ack(e, b, ok);
        chk({nm, "_ack"}, 256'(ok), 256'd1);
        chk({nm, "_lat"}, 256'(e), 256'(LAT));
        chk({nm, "_busy"}, 256'(b), 256'(LAT));
        q  = dout;
        en = 1'b0;
        @(negedge clk);
        chk({nm, "_ackpulse"}, 256'(ack), 256'd0);
        chk({nm, "_idle"}, 256'(busy), 256'd0);
    endtask

    initial begin
        line_t q;
        int    e;
        int    b;
        int    nack;
        bit    ok;
        bit    w;
        logic [31:0] a;
        line_t d;
        line_t exp;
        logic [8:0] ix;

        rst  = 1'b1;
        en   = 1'b0;
        wr_s = 1'b0;
        addr = '0;
        din  = '0;

        for (int i = 0; i < DEPTH; i++) begin
            model[i] = {8{32'(i) ^ 32'hA0A0_0000}};
        end
        model[3] = {32{8'hA5}};
        model[5] = {32{8'hC3}};
        for (int i = 0; i < DEPTH; i++) begin
            dut.u_array.mem[i] = model[i];
        end

        repeat (3) @(negedge clk);
        chk("rst_ack", 256'(ack), 256'd0);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_data", dout, 256'd0);
        rst  = 1'b0;
        hold = '0;

        tbl[0] = '{1'b0, 32'h0000_0060, '0, {32{8'hA5}}};
        tbl[1] = '{1'b1, 32'h0000_0080, 256'h1234, {32{8'hA5}}};
        tbl[2] = '{1'b0, 32'h0000_0080, '0, 256'h1234};
        tbl[3] = '{1'b1, 32'h0000_4020, 256'hBEEF, 256'h1234};
        tbl[4] = '{1'b0, 32'h0000_0020, '0, 256'hBEEF};
        tbl[5] = '{1'b1, 32'hFFFF_FFE0, {256{1'b1}}, 256'hBEEF};
        tbl[6] = '{1'b0, 32'h0000_3FE0, '0, {256{1'b1}}};
        tbl[7] = '{1'b0, 32'h0000_00BF, '0, {32{8'hC3}}};

        for (int i = 0; i < 8; i++) begin
            xact(tbl[i].wr, tbl[i].addr, tbl[i].data,
                 $sformatf("vec%0d", i), q);
            chk($sformatf("vec%0d_data", i), q, tbl[i].exp);
            if (tbl[i].wr) model[tbl[i].addr[13:5]] = tbl[i].data;
            else hold = tbl[i].exp;
        end

        // inputs changed and enable dropped while the read is in flight
        @(negedge clk);
        en   = 1'b1;
        wr_s = 1'b0;
        addr = 32'h20;
        din  = '0;
        @(posedge clk);
        @(negedge clk);
        chk("ign_busy1", 256'(busy), 256'd1);
        en   = 1'b0;
        wr_s = 1'b1;
        addr = 32'h40;
        din  = {8{32'hDEAD_BEEF}};
        wait_ack(e, b, ok);
        chk("ign_ack", 256'(ok), 256'd1);
        chk("ign_lat", 256'(e + 1), 256'(LAT));
        chk("ign_data", dout, model[1]);
        hold = model[1];
        wr_s = 1'b0;
        @(negedge clk);
        xact(1'b0, 32'h40, '0, "ign_line2", q);
        chk("ign_line2_data", q, model[2]);
        hold = model[2];

        // enable held through the ack cycle
        @(negedge clk);
        en   = 1'b1;
        wr_s = 1'b0;
        addr = 32'h60;
        wait_ack(e, b, ok);
        chk("hold_ack1", 256'(ok), 256'd1);
        chk("hold_lat1", 256'(e), 256'(LAT));
        wait_ack(e, b, ok);
        chk("hold_ack2", 256'(ok), 256'd1);
        chk("hold_lat2", 256'(e), 256'(LAT + 1));
        chk("hold_busy2", 256'(b), 256'(LAT));
        chk("hold_data", dout, model[3]);
        hold = model[3];
        en   = 1'b0;
        @(negedge clk);
        chk("hold_idle", 256'(busy), 256'd0);

        // reset while a write is in flight: write dropped, no ack
        @(negedge clk);
        en   = 1'b1;
        wr_s = 1'b1;
        addr = 32'h80;
        din  = {8{32'h0BAD_F00D}};
        @(posedge clk);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_ack", 256'(ack), 256'd0);
        chk("rmid_busy", 256'(busy), 256'd0);
        chk("rmid_data", dout, 256'd0);
        rst  = 1'b0;
        hold = '0;
        nack = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) nack++;
        end
        chk("rmid_noack", 256'(nack), 256'd0);
        xact(1'b0, 32'h80, '0, "rmid_rd", q);
        chk("rmid_rd_data", q, model[4]);
        hold = model[4];

        // random traffic against the line model
        for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
            ix = a[13:5];
            exp = w ? hold : model[ix];
            xact(w, a, d, $sformatf("rnd%0d", n), q);
            chk($sformatf("rnd%0d_data", n), q, exp);
            if (w) model[ix] = d;
            else hold = model[ix];
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
